cp0_timer_ctrl: RTL and testbench
=================================

// Module: cp0_timer_ctrl
// PURPOSE
//  Parametrised coprocessor-0 for the pipelined MIPS core. Holds SR, Cause, EPC and PrID
//  and arbitrates hardware interrupts and exceptions at the macro-op commit point (M stage).
//  Also carries an internal Count/Compare timer that raises a latched timer interrupt.
//  The timer is compiled in only with CP0_TIMER_EN.
// PARAMETERS
//  NUM_HWINT  6             number of external interrupt lines, 1..6, mapped to IM/IP bit 10 upward
//  PRID_VAL   32'hDEAD_C0DE reset and constant value of PrID (reg 15)
//  CNT_W      32            Count/Compare width, 1..32, zero-extended on read
// PORTS
//  clk          in   1          clock, all state on posedge
//  reset        in   1          synchronous, active-high
//  en           in   1          mtc0 write strobe
//  cp0_addr     in   5          register select for read and write
//  cp0_in       in   32         mtc0 write data
//  cp0_out      out  32         mfc0 read data, combinational
//  vpc          in   32         PC of the instruction at commit
//  bd_in        in   1          commit instruction is in a delay slot
//  exc_code_in  in   5          exception code; 0 means none
//  hw_int       in   NUM_HWINT  external interrupt levels
//  exl_clr      in   1          eret commit, clears EXL
//  epc_out      out  32         current EPC
//  req          out  1          flush pipeline and redirect to the handler this cycle
//  timer_irq    out  1          latched timer-interrupt pending bit (0 without CP0_TIMER_EN)
// BEHAVIOUR
//  Reset: SR=0, Cause=0, EPC=0, Count=0, Compare=0, ti=0, PrID=PRID_VAL.
//   Outputs after reset: req=0, epc_out=0, timer_irq=0.
//  Fields: SR.IM=SR[10+:NUM_HWINT], SR.TM=SR[16], EXL=SR[1], IE=SR[0];
//   Cause.BD=[31], Cause.TI=[30], IP=[10+:NUM_HWINT], ExcCode=[6:2].
//  int_req = (|(hw_int & IM) | (ti & TM)) & ~EXL & IE.
//  exc_req = (|exc_code_in) & ~EXL.
//  req = int_req | exc_req, combinational, same cycle as the inputs.
//  On req: ExcCode <= int_req ? 0 : exc_code_in; EXL <= 1; BD <= bd_in;
//   EPC <= bd_in ? vpc-4 : vpc. Interrupt has priority over exception.
//  mtc0 (en & ~req): reg 12 writes SR, reg 14 writes EPC, reg 9 writes Count,
//   reg 11 writes Compare. Writes to 13 and 15 are ignored.
//  Priority on SR/EPC in one cycle: req > mtc0.
//   req and en together: the write is dropped.
//   exl_clr and req together: EXL ends at 1.
//   exl_clr and mtc0-SR together (no req): the mtc0 data wins.
//  Every cycle: IP <= hw_int; TI <= ti.
//  cp0_out: 9 Count, 11 Compare, 12 SR, 13 Cause, 14 EPC, 15 PrID, else 0.
//   The read returns pre-edge values; there is no write-through bypass.
//  Timer (CP0_TIMER_EN only):
//   - Count increments by 1 each cycle and wraps at 2^CNT_W-1 -> 0.
//   - mtc0 to Count loads cp0_in[CNT_W-1:0] and overrides that cycle's increment.
//   - When Count==Compare and Compare!=0 after the update, ti <= 1 (sticky).
//   - mtc0 to Compare clears ti. Clear wins over a same-cycle match.
//   - timer_irq = ti.
// CONFIGURATION
//  CP0_TIMER_EN defined:
//   Count/Compare/ti exist; regs 9/11 are readable and writable; SR.TM and Cause.TI are live.
//  CP0_TIMER_EN undefined:
//   No timer logic. Regs 9/11 read 0 and writes are ignored.
//   SR[16] is still stored but has no effect. Cause.TI=0, timer_irq=0.
// TESTING
//  1. Reset, then write SR=32'h0000_0401, hw_int[0]=1 -> req=1 same cycle;
//     next cycle Cause.ExcCode=0, EXL=1, EPC=vpc.
//  2. exc_code_in=5'd4, bd_in=1, vpc=32'h3008, EXL=0 -> req=1; EPC=32'h3004, Cause=32'h8000_0010.
//  3. en=1 write EPC=32'h4000 in the same cycle as exc_code_in=5'd10 -> EPC=vpc, not 32'h4000.
//  4. EXL=1, IE=1, IM all set, hw_int all 1 -> req=0; exl_clr pulse -> req=1 the next cycle.
//  5. [TIMER_EN] Write Compare=5, Count=0, SR=32'h0001_0001
//     -> ti=1 and req=1 once Count reaches 5; mtc0 Compare clears ti.
//  6. [TIMER_EN] Count=32'hFFFF_FFFF -> reads 0 next cycle; with the macro undefined, reg 9 reads 0.

Source files
------------

// File: rtl/cp0_timer_ctrl_if.sv
// rtl/cp0_timer_ctrl_if.sv - coprocessor-0 commit/mtc0/mfc0 bundle between the pipeline and CP0
// Purpose: groups the register-access and commit-point signals of cp0_timer_ctrl.
// Signals:
//   en, cp0_addr, cp0_in   mtc0 strobe, register select, write data
//   cp0_out                mfc0 read data
//   vpc, bd_in, exc_code_in, hw_int, exl_clr   commit-point inputs
//   epc_out, req, timer_irq                    CP0 status outputs
// Modports: master = pipeline side, slave = CP0 side.
interface cp0_timer_ctrl_if #(
  parameter int NUM_HWINT = 6
);
  logic                 en;
  logic [4:0]           cp0_addr;
  logic [31:0]          cp0_in;
  logic [31:0]          cp0_out;
  logic [31:0]          vpc;
  logic                 bd_in;
  logic [4:0]           exc_code_in;
  logic [NUM_HWINT-1:0] hw_int;
  logic                 exl_clr;
  logic [31:0]          epc_out;
  logic                 req;
  logic                 timer_irq;

  modport master (
    output en, cp0_addr, cp0_in, vpc, bd_in, exc_code_in, hw_int, exl_clr,
    input  cp0_out, epc_out, req, timer_irq
  );

  modport slave (
    input  en, cp0_addr, cp0_in, vpc, bd_in, exc_code_in, hw_int, exl_clr,
    output cp0_out, epc_out, req, timer_irq
  );
endinterface

// File: rtl/cp0_timer_ctrl.sv
// rtl/cp0_timer_ctrl.sv - coprocessor-0 SR/Cause/EPC/PrID with commit-point interrupt/exception arbitration
// Purpose: holds SR, Cause, EPC and PrID, raises req (pipeline flush + redirect) for enabled
//   interrupts and exceptions at commit, and optionally a Count/Compare timer.
// Ports:
//   clk    clock, all state on posedge
//   reset  synchronous, active-high
//   bus    cp0_timer_ctrl_if.slave: mtc0/mfc0 access, commit inputs, req/epc_out/timer_irq
// Build option: define CP0_TIMER_EN to include Count (reg 9), Compare (reg 11) and the
//   sticky timer interrupt; without it regs 9/11 read 0, SR.TM is inert, timer_irq=0.
module cp0_timer_ctrl #(
  parameter int          NUM_HWINT = 6,
  parameter logic [31:0] PRID_VAL  = 32'hDEAD_C0DE,
  parameter int          CNT_W     = 32
) (
  input  logic            clk,
  input  logic            reset,
  cp0_timer_ctrl_if.slave bus
);
  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_SR      = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;
  localparam logic [4:0] A_PRID    = 5'd15;

  logic [31:0]          sr;
  logic [31:0]          epc;
  logic                 cause_bd;
  logic                 cause_ti;
  logic [NUM_HWINT-1:0] cause_ip;
  logic [4:0]           cause_exc;
  logic [31:0]          cause;

  logic                 ti;
  logic                 tm_hit;
  logic [31:0]          count_rd;
  logic [31:0]          compare_rd;

  logic                 int_req;
  logic                 exc_req;
  logic                 req;
  logic                 wr;
  logic [31:0]          rd;

  assign int_req = ((|(bus.hw_int & sr[10 +: NUM_HWINT])) | tm_hit) & ~sr[1] & sr[0];
  assign exc_req = (|bus.exc_code_in) & ~sr[1];
  assign req     = int_req | exc_req;

  // A taken interrupt/exception owns SR/EPC this cycle, so a coincident mtc0 is dropped.
  assign wr = bus.en & ~req;

`ifdef CP0_TIMER_EN
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] compare;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] compare_nxt;
  logic             ti_nxt;

  always_comb begin
    count_nxt   = count + CNT_W'(1);
    compare_nxt = compare;
    ti_nxt      = ti;
    if (wr && bus.cp0_addr == A_COUNT) count_nxt = bus.cp0_in[CNT_W-1:0];
    if (wr && bus.cp0_addr == A_COMPARE) compare_nxt = bus.cp0_in[CNT_W-1:0];
    // Match is judged on post-update values; a Compare write acknowledges and beats a match.
    if (wr && bus.cp0_addr == A_COMPARE) ti_nxt = 1'b0;
    else if (count_nxt == compare_nxt && compare_nxt != '0) ti_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      count   <= count_nxt;
      compare <= compare_nxt;
      ti      <= ti_nxt;
    end
  end

  assign tm_hit     = ti & sr[16];
  assign count_rd   = 32'(count);
  assign compare_rd = 32'(compare);
`else
  assign ti         = 1'b0;
  assign tm_hit     = 1'b0;
  assign count_rd   = 32'd0;
  assign compare_rd = 32'd0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sr        <= '0;
      epc       <= '0;
      cause_bd  <= 1'b0;
      cause_ti  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
    end else begin
      cause_ip <= bus.hw_int;
      cause_ti <= ti;
      if (req) begin
        cause_exc <= int_req ? 5'd0 : bus.exc_code_in;
        cause_bd  <= bus.bd_in;
        sr[1]     <= 1'b1;
        epc       <= bus.bd_in ? bus.vpc - 32'd4 : bus.vpc;
      end else begin
        // mtc0 SR carries its own EXL value, which overrides a same-cycle eret.
        if (wr && bus.cp0_addr == A_SR) sr <= bus.cp0_in;
        else if (bus.exl_clr) sr[1] <= 1'b0;
        if (wr && bus.cp0_addr == A_EPC) epc <= bus.cp0_in;
      end
    end
  end

  always_comb begin
    cause                  = '0;
    cause[31]              = cause_bd;
    cause[30]              = cause_ti;
    cause[10 +: NUM_HWINT] = cause_ip;
    cause[6:2]             = cause_exc;
  end

  always_comb begin
    rd = 32'd0;
    case (bus.cp0_addr)
      A_COUNT:   rd = count_rd;
      A_COMPARE: rd = compare_rd;
      A_SR:      rd = sr;
      A_CAUSE:   rd = cause;
      A_EPC:     rd = epc;
      A_PRID:    rd = PRID_VAL;
      default:   rd = 32'd0;
    endcase
  end

  assign bus.cp0_out   = rd;
  assign bus.epc_out   = epc;
  assign bus.req       = req;
  assign bus.timer_irq = ti;
endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// tb/tb_cp0_timer_ctrl.sv - scoreboard bench for cp0_timer_ctrl
module tb_cp0_timer_ctrl;
  localparam int SEL_REQ = 32;
  localparam int SEL_EPC = 33;
  localparam int SEL_TI  = 34;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   edges;
  sb_t  sb[$];

  cp0_timer_ctrl_if #(.NUM_HWINT(6)) bus();

  cp0_timer_ctrl #(.NUM_HWINT(6), .PRID_VAL(32'hDEAD_C0DE), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic sample(input int sel, output logic [31:0] got);
    if (sel < 32) bus.cp0_addr = 5'(sel);
    #1;
    case (sel)
      SEL_REQ: got = {31'd0, bus.req};
      SEL_EPC: got = bus.epc_out;
      SEL_TI:  got = {31'd0, bus.timer_irq};
      default: got = bus.cp0_out;
    endcase
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.en = 1'b1;
    bus.cp0_addr = a;
    bus.cp0_in = d;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
  endtask

  task automatic test_reset;
    sb_t e;
    logic [31:0] got;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back('{"rst_req", SEL_REQ, 32'd0});
    sb.push_back('{"rst_epc_out", SEL_EPC, 32'd0});
    sb.push_back('{"rst_timer_irq", SEL_TI, 32'd0});
    sb.push_back('{"rst_sr", 12, 32'd0});
    sb.push_back('{"rst_cause", 13, 32'd0});
    sb.push_back('{"rst_epc", 14, 32'd0});
    sb.push_back('{"rst_prid", 15, 32'hDEAD_C0DE});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      sample(e.sel, got);
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_hw_int;
    sb_t e;
    logic [31:0] got;
    mtc0(5'd12, 32'h0000_0401);
    @(negedge clk);
    bus.hw_int = 6'h01;
    bus.vpc = 32'h0000_1000;
    sb.push_back('{"hwint_req", SEL_REQ, 32'd1});
    e = sb.pop_front();
    sample(e.sel, got);
    total++;
    if (got !== e.exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
    end
    @(posedge clk);
    #1;
    bus.hw_int = 6'h00;
    sb.push_back('{"hwint_cause", 13, 32'h0000_0400});
    sb.push_back('{"hwint_sr", 12, 32'h0000_0403});
    sb.push_back('{"hwint_epc", 14, 32'h0000_1000});
    sb.push_back('{"hwint_epc_out", SEL_EPC, 32'h0000_1000});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      sample(e.sel, got);
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      end
    end
  endtask

  task automatic test_exception;
    sb_t e;
    logic [31:0] got;
    mtc0(5'd12, 32'd0);
    @(negedge clk);
    bus.exc_code_in = 5'd4;
    bus.bd_in = 1'b1;
    bus.vpc = 32'h0000_3008;
    sb.push_back('{"exc_req", SEL_REQ, 32'd1});
    e = sb.pop_front();
    sample(e.sel, got);
    total++;
    if (got !== e.exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
    end
    @(posedge clk);
    #1;
    bus.exc_code_in = 5'd0;
    bus.bd_in = 1'b0;
    sb.push_back('{"exc_epc_bd", 14, 32'h0000_3004});
    sb.push_back('{"exc_cause", 13, 32'h8000_0010});
    sb.push_back('{"exc_sr_exl", 12, 32'h0000_0002});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      sample(e.sel, got);
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      end
    end
  endtask

  task automatic test_write_drop;
    sb_t e;
    logic [31:0] got;
    mtc0(5'd12, 32'd0);
    @(negedge clk);
    bus.en = 1'b1;
    bus.cp0_addr = 5'd14;
    bus.cp0_in = 32'h0000_4000;
    bus.exc_code_in = 5'd10;
    bus.vpc = 32'h0000_5000;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    bus.exc_code_in = 5'd0;
    sb.push_back('{"drop_epc", 14, 32'h0000_5000});
    sb.push_back('{"drop_cause", 13, 32'h0000_0028});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      sample(e.sel, got);
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      end
    end
  endtask

  task automatic test_exl_priority;
    sb_t e;
    logic [31:0] got;
    mtc0(5'd12, 32'h0000_FC03);
    @(negedge clk);
    bus.hw_int = 6'h3F;
    bus.exl_clr = 1'b1;
    sb.push_back('{"exl_masks_req", SEL_REQ, 32'd0});
    e = sb.pop_front();
    sample(e.sel, got);
    total++;
    if (got !== e.exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
    end
    @(posedge clk);
    #1;
    bus.exl_clr = 1'b0;
    bus.vpc = 32'h0000_7000;
    sb.push_back('{"eret_req", SEL_REQ, 32'd1});
    sb.push_back('{"eret_sr", 12, 32'h0000_FC01});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      sample(e.sel, got);
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      end
    end
    bus.exl_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.exl_clr = 1'b0;
    bus.hw_int = 6'h00;
    sb.push_back('{"req_beats_eret_sr", 12, 32'h0000_FC03});
    sb.push_back('{"int_epc", 14, 32'h0000_7000});
    sb.push_back('{"int_cause_ip", 13, 32'h0000_FC00});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      sample(e.sel, got);
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      end
    end
    @(negedge clk);
    bus.exl_clr = 1'b1;
    bus.en = 1'b1;
    bus.cp0_addr = 5'd12;
    bus.cp0_in = 32'h0000_0002;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    bus.exl_clr = 1'b0;
    mtc0(5'd13, 32'hFFFF_FFFF);
    mtc0(5'd15, 32'h0000_0000);
    sb.push_back('{"mtc0_beats_eret_sr", 12, 32'h0000_0002});
    sb.push_back('{"cause_ro", 13, 32'h0000_0000});
    sb.push_back('{"prid_ro", 15, 32'hDEAD_C0DE});
    sb.push_back('{"unmapped_reg0", 0, 32'h0000_0000});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      sample(e.sel, got);
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      end
    end
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer;
    sb_t e;
    logic [31:0] got;
    int w;
    logic [31:0] cmp;
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    w = edges;
    mtc0(5'd12, 32'h0001_0001);
    for (int i = 0; i < 20; i++) begin
      if (bus.timer_irq) break;
      @(posedge clk);
      #1;
    end
    sb.push_back('{"tmr_irq_set", SEL_TI, 32'd1});
    sb.push_back('{"tmr_count_at_match", 9, 32'd5});
    sb.push_back('{"tmr_req", SEL_REQ, 32'd1});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      sample(e.sel, got);
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      end
    end
    @(posedge clk);
    #1;
    sb.push_back('{"tmr_cause_ti", 13, 32'h4000_0000});
    sb.push_back('{"tmr_sr_exl", 12, 32'h0001_0003});
    sb.push_back('{"tmr_sticky", SEL_TI, 32'd1});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      sample(e.sel, got);
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      end
    end
    @(negedge clk);
    cmp = 32'(edges + 1 - w);
    bus.en = 1'b1;
    bus.cp0_addr = 5'd11;
    bus.cp0_in = cmp;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    sb.push_back('{"tmr_clear_beats_match", SEL_TI, 32'd0});
    sb.push_back('{"tmr_compare", 11, cmp});
    sb.push_back('{"tmr_count_eq_compare", 9, cmp});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      sample(e.sel, got);
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      end
    end
    mtc0(5'd9, 32'hFFFF_FFFF);
    sb.push_back('{"tmr_count_max", 9, 32'hFFFF_FFFF});
    e = sb.pop_front();
    sample(e.sel, got);
    total++;
    if (got !== e.exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
    end
    @(posedge clk);
    #1;
    sb.push_back('{"tmr_count_wrap", 9, 32'd0});
    e = sb.pop_front();
    sample(e.sel, got);
    total++;
    if (got !== e.exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
    end
  endtask
`else
  task automatic test_timer;
    sb_t e;
    logic [31:0] got;
    mtc0(5'd12, 32'h0001_0001);
    mtc0(5'd9, 32'hFFFF_FFFF);
    mtc0(5'd11, 32'd5);
    sb.push_back('{"notmr_sr_tm_stored", 12, 32'h0001_0001});
    sb.push_back('{"notmr_req", SEL_REQ, 32'd0});
    sb.push_back('{"notmr_count", 9, 32'd0});
    sb.push_back('{"notmr_compare", 11, 32'd0});
    sb.push_back('{"notmr_irq", SEL_TI, 32'd0});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      sample(e.sel, got);
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      end
    end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    edges = 0;
    reset = 1'b1;
    bus.en = 1'b0;
    bus.cp0_addr = 5'd0;
    bus.cp0_in = 32'd0;
    bus.vpc = 32'd0;
    bus.bd_in = 1'b0;
    bus.exc_code_in = 5'd0;
    bus.hw_int = 6'h00;
    bus.exl_clr = 1'b0;
    test_reset();
    test_hw_int();
    test_exception();
    test_write_drop();
    test_exl_priority();
    test_timer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
